ea_sequencer: RTL and testbench
===============================

# ea_sequencer

Memory-reference address sequencer sitting directly downstream of the IR decoder. Given the latched IR, the latched PC and the decoder's addressing flags (DIR, IND, PPIND, MP), it resolves the 12-bit effective address for AND/TAD/ISZ/DCA/JMS/JMP:
- direct: no memory access;
- indirect: one memory read;
- auto-index (locations 0010–0017 of page 0): read, increment, write back.

It hands the final EA to the execute stage with a one-cycle DONE pulse.

## Interface
Parameters:
- AW, 12, address and data width (PDP-8 word)

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  request: begin EA resolution for current IR/PCLATCHED/flags; sampled only in IDLE
- IR  in  AW  latched instruction register
- PCLATCHED  in  AW  PC of the instruction being executed
- DIR  in  1  direct addressing flag from decoder
- IND  in  1  indirect, non-auto-index flag from decoder
- PPIND  in  1  indirect through auto-index location flag from decoder
- MP  in  1  current-page bit (IR[7]) from decoder
- MEM_ADDR  out  AW  memory address, registered
- MEM_RD  out  1  read strobe, held until MEM_ACK
- MEM_WR  out  1  write strobe, held until MEM_ACK
- MEM_WDATA  out  AW  write data, registered
- MEM_RDATA  in  AW  read data, valid in the MEM_ACK cycle of a read
- MEM_ACK  in  1  single-cycle completion of the pending read/write
- BUSY  out  1  high in every non-IDLE state
- DONE  out  1  one-cycle pulse: EA valid
- EA  out  AW  resolved effective address; held until next accepted START or RESET

## Operation
- Page address: PA = MP ? {PCLATCHED[11:7], IR[6:0]} : {5'b0, IR[6:0]}. Captured at START.
- Flag priority if more than one flag is set (illegal per decode): PPIND > IND > DIR. If no flag is set, treat as DIR.
- States:
  - IDLE: on START:
    - DIR → FIN with EA=PA;
    - IND/PPIND → RD with MEM_ADDR=PA, MEM_RD=1.
  - RD: wait MEM_ACK.
    - On ack, IND → FIN with EA=MEM_RDATA.
    - On ack, PPIND → WR with MEM_ADDR unchanged, MEM_WDATA=MEM_RDATA+1, MEM_WR=1, EA=MEM_RDATA+1.
  - WR: wait MEM_ACK → FIN.
  - FIN: DONE=1 for exactly one cycle → IDLE.
- Increment is modulo 2^AW (7777 + 1 = 0000 octal).
- START outside IDLE is ignored; no queueing.
- MEM_RD and MEM_WR are never both high. Each strobe deasserts on the edge following its MEM_ACK.
- MEM_ACK while no strobe is pending is ignored.
- The block does not re-check page-0/offset for PPIND; it trusts the decoder.

## Timing
- Reset values: state IDLE; MEM_ADDR=0, MEM_RD=0, MEM_WR=0, MEM_WDATA=0, BUSY=0, DONE=0, EA=0.
- RESET mid-operation:
  - next edge forces IDLE and drops strobes;
  - an interrupted write is abandoned;
  - no DONE is produced.
- DIR latency: START at edge 0 → DONE high in cycle 1.
- IND latency: MEM_RD high from cycle 1; MEM_ACK in cycle k → DONE in cycle k+1.
- PPIND latency: read ack in cycle k → MEM_WR high in cycle k+1; write ack in cycle m → DONE in cycle m+1.
- A zero-wait memory (ACK in the first strobe cycle) gives:
  - IND: DONE at cycle 2;
  - PPIND: DONE at cycle 3.
- EA is stable from the DONE cycle onward. START may be reasserted in the cycle after DONE.

## Structure
- Shared package pdp8_pkg holds:
  - state enum ea_state_t {IDLE, RD, WR, FIN};
  - constant AUTOINC_BASE = 12'o0010;
  - the PDP-8 word width.
- One natural sub-module: page_addr, the combinational PA mux from IR/PCLATCHED/MP, reused by the fetch path.
- Everything else stays in a single always block plus output registers.

## Test plan
- DIR, MP=0, IR=1123 octal → DONE in cycle 1, EA=0123, MEM_RD/MEM_WR never asserted.
- DIR, MP=1, PCLATCHED=4200, IR=1234 octal → EA=4234.
- IND, PA=0300 octal, memory returns 5555 after 2 wait cycles → one read at 0300, DONE 1 cycle after ack, EA=5555, no write.
- PPIND, PA=0010, memory holds 7777 → read 0010; write 0000 to 0010; EA=0000; DONE after write ack.
- START pulsed while BUSY, plus spurious MEM_ACK in IDLE → no extra access and no extra DONE.
- RESET asserted during the WR state → next cycle IDLE with all outputs 0; a following DIR START completes normally.

Source files
------------

// File: rtl/pdp8_pkg.sv
// pdp8_pkg
// Shared PDP-8 definitions for the address-resolution and fetch paths.
//   PDP8_WORD_W  : machine word width (address and data)
//   AUTOINC_BASE : first auto-index location on page 0 (0010..0017 octal)
//   ea_state_t   : effective-address sequencer state encoding
package pdp8_pkg;

  localparam int PDP8_WORD_W = 12;

  localparam logic [PDP8_WORD_W-1:0] AUTOINC_BASE = 12'o0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } ea_state_t;

endpackage

// File: rtl/ea_sequencer_page_addr.sv
// page_addr
// Combinational page-address mux shared by the fetch and EA paths.
//   i_ir  : instruction register (only the 7-bit page offset is used)
//   i_pc  : PC of the instruction (only the page number is used)
//   i_mp  : current-page select
//   o_pa  : page address, current page or page 0
module page_addr
  import pdp8_pkg::*;
#(
  parameter int AW = PDP8_WORD_W
) (
  input  logic [AW-1:0] i_ir,
  input  logic [AW-1:0] i_pc,
  input  logic          i_mp,
  output logic [AW-1:0] o_pa
);

  // Opcode bits of IR and offset bits of PC do not take part in the mux.
  logic w_unused;
  assign w_unused = ^{i_ir[AW-1:7], i_pc[6:0]};

  assign o_pa = i_mp ? {i_pc[AW-1:7], i_ir[6:0]}
                     : {{(AW-7){1'b0}}, i_ir[6:0]};

endmodule

// File: rtl/ea_sequencer.sv
// ea_sequencer
// Resolves the effective address of a memory-reference instruction:
// direct (no access), indirect (one read) or auto-index (read, increment,
// write back), then pulses DONE for one cycle with EA valid.
//   CLK, RESET              : clock, synchronous active-high reset
//   START                   : begin resolution (sampled only in IDLE)
//   IR, PCLATCHED           : latched instruction and its PC
//   DIR, IND, PPIND, MP     : decoder addressing flags
//   MEM_ADDR/RD/WR/WDATA    : registered memory request
//   MEM_RDATA, MEM_ACK      : memory response
//   BUSY, DONE, EA          : status and result
//
// state | meaning
// IDLE  | waiting for START
// RD    | read of pointer word pending, MEM_RD high
// WR    | write-back of incremented pointer pending, MEM_WR high
// FIN   | EA valid, DONE high for this single cycle
module ea_sequencer
  import pdp8_pkg::*;
#(
  parameter int AW = PDP8_WORD_W
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [AW-1:0] IR,
  input  logic [AW-1:0] PCLATCHED,
  input  logic          DIR,
  input  logic          IND,
  input  logic          PPIND,
  input  logic          MP,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_RD,
  output logic          MEM_WR,
  output logic [AW-1:0] MEM_WDATA,
  input  logic [AW-1:0] MEM_RDATA,
  input  logic          MEM_ACK,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] EA
);

  ea_state_t     r_state;
  ea_state_t     w_next_state;
  logic [AW-1:0] w_pa;
  logic [AW-1:0] w_inc;
  logic          w_indirect;
  logic          w_dir_unused;
  logic          r_auto;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [AW-1:0] r_mem_wdata;
  logic [AW-1:0] r_ea;

  page_addr #(.AW(AW)) u_page_addr (
    .i_ir (IR),
    .i_pc (PCLATCHED),
    .i_mp (MP),
    .o_pa (w_pa)
  );

  // PPIND outranks IND; anything else, including no flag at all, is direct,
  // so DIR itself never changes the outcome.
  assign w_indirect   = PPIND | IND;
  assign w_dir_unused = DIR;
  assign w_inc        = MEM_RDATA + {{(AW-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_next_state = w_indirect ? RD : FIN;
        end
      end
      RD: begin
        if (MEM_ACK) begin
          w_next_state = r_auto ? WR : FIN;
        end
      end
      WR: begin
        if (MEM_ACK) begin
          w_next_state = FIN;
        end
      end
      FIN: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Registered datapath outputs; they advance on the same edges as r_state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_auto      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_ea        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            if (w_indirect) begin
              r_auto     <= PPIND;
              r_mem_addr <= w_pa;
              r_mem_rd   <= 1'b1;
            end else begin
              r_ea <= w_pa;
            end
          end
        end
        RD: begin
          if (MEM_ACK) begin
            r_mem_rd <= 1'b0;
            if (r_auto) begin
              // Write back to the same pointer location; MEM_ADDR is held.
              r_mem_wr    <= 1'b1;
              r_mem_wdata <= w_inc;
              r_ea        <= w_inc;
            end else begin
              r_ea <= MEM_RDATA;
            end
          end
        end
        WR: begin
          if (MEM_ACK) begin
            r_mem_wr <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    BUSY = (r_state != IDLE);
    DONE = (r_state == FIN);
  end

  assign MEM_ADDR  = r_mem_addr;
  assign MEM_RD    = r_mem_rd;
  assign MEM_WR    = r_mem_wr;
  assign MEM_WDATA = r_mem_wdata;
  assign EA        = r_ea;

endmodule

// File: tb/tb_ea_sequencer.sv
module tb_ea_sequencer;

  localparam int AW = 12;

  logic          CLK;
  logic          RESET;
  logic          START;
  logic [AW-1:0] IR;
  logic [AW-1:0] PCLATCHED;
  logic          DIR;
  logic          IND;
  logic          PPIND;
  logic          MP;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_RD;
  logic          MEM_WR;
  logic [AW-1:0] MEM_WDATA;
  logic [AW-1:0] MEM_RDATA;
  logic          MEM_ACK;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] EA;

  ea_sequencer #(.AW(AW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .IR        (IR),
    .PCLATCHED (PCLATCHED),
    .DIR       (DIR),
    .IND       (IND),
    .PPIND     (PPIND),
    .MP        (MP),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (MEM_ACK),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .EA        (EA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string         name;
    logic          dir;
    logic          ind;
    logic          ppind;
    logic          mp;
    logic [AW-1:0] ir;
    logic [AW-1:0] pc;
    logic [AW-1:0] rdata;
    int            waits;
    int            hold;
    logic [AW-1:0] exp_ea;
    int            exp_done;
    int            exp_reads;
    int            exp_writes;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_wdata;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic dir, input logic ind,
                              input logic ppind, input logic mp,
                              input logic [AW-1:0] ir, input logic [AW-1:0] pc,
                              input logic [AW-1:0] rdata, input int waits, input int hold,
                              input logic [AW-1:0] exp_ea, input int exp_done,
                              input int exp_reads, input int exp_writes,
                              input logic [AW-1:0] exp_addr, input logic [AW-1:0] exp_wdata);
    vec_t v;
    v.name = name; v.dir = dir; v.ind = ind; v.ppind = ppind; v.mp = mp;
    v.ir = ir; v.pc = pc; v.rdata = rdata; v.waits = waits; v.hold = hold;
    v.exp_ea = exp_ea; v.exp_done = exp_done; v.exp_reads = exp_reads;
    v.exp_writes = exp_writes; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // One transaction: START presented before edge 0, cycle c is the cycle
  // following edge c-1. The memory model acks each strobe after 'waits'
  // extra cycles and checks every observable result against the vector.
  task automatic run_txn(input vec_t v);
    int done_cycle = 0;
    int ndone = 0;
    int nreads = 0;
    int nwrites = 0;
    int overlap = 0;
    int rd_wait = 0;
    int wr_wait = 0;
    logic [AW-1:0] ea_s = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] wr_data = '0;
    @(negedge CLK);
    IR = v.ir; PCLATCHED = v.pc; DIR = v.dir; IND = v.ind; PPIND = v.ppind; MP = v.mp;
    START = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      MEM_ACK = 1'b0;
      START = (c < v.hold);
      if (MEM_RD && MEM_WR) overlap++;
      if (DONE) begin
        ndone++;
        if (done_cycle == 0) begin
          done_cycle = c;
          ea_s = EA;
        end
      end
      if (MEM_RD) begin
        rd_wait++;
        if (rd_wait > v.waits) begin
          MEM_ACK = 1'b1;
          MEM_RDATA = v.rdata;
          nreads++;
          rd_addr = MEM_ADDR;
          rd_wait = 0;
        end
      end else if (MEM_WR) begin
        wr_wait++;
        if (wr_wait > v.waits) begin
          MEM_ACK = 1'b1;
          nwrites++;
          wr_addr = MEM_ADDR;
          wr_data = MEM_WDATA;
          wr_wait = 0;
        end
      end
      if (done_cycle > 0 && c >= done_cycle + 3) break;
    end
    MEM_ACK = 1'b0;
    START = 1'b0;
    if (done_cycle == 0) begin
      failures++;
      checks++;
      $display("FAIL %s timeout: no DONE within 60 cycles", v.name);
    end else begin
      chk({v.name, " done_cycle"}, done_cycle, v.exp_done);
      chk({v.name, " ea"}, ea_s, v.exp_ea);
    end
    chk({v.name, " done_count"}, ndone, 1);
    chk({v.name, " reads"}, nreads, v.exp_reads);
    chk({v.name, " writes"}, nwrites, v.exp_writes);
    chk({v.name, " rd_wr_overlap"}, overlap, 0);
    if (v.exp_reads > 0) chk({v.name, " rd_addr"}, rd_addr, v.exp_addr);
    if (v.exp_writes > 0) begin
      chk({v.name, " wr_addr"}, wr_addr, v.exp_addr);
      chk({v.name, " wr_data"}, wr_data, v.exp_wdata);
    end
    chk({v.name, " busy_after"}, BUSY, 0);
    chk({v.name, " ea_held"}, EA, v.exp_ea);
  endtask

  vec_t vecs[10];

  initial begin
    int found;
    //            name       dir  ind  ppi  mp   ir       pc       rdata    w  h  exp_ea   dn rd wr addr     wdata
    vecs[0] = mk("dir_p0",   1,   0,   0,   0,   12'o1123,12'o0000,12'o0000,0, 1, 12'o0123,1, 0, 0, 12'o0000,12'o0000);
    vecs[1] = mk("dir_cur",  1,   0,   0,   1,   12'o1234,12'o4200,12'o0000,0, 1, 12'o4234,1, 0, 0, 12'o0000,12'o0000);
    vecs[2] = mk("ind_w2",   0,   1,   0,   1,   12'o1500,12'o0250,12'o5555,2, 1, 12'o5555,4, 1, 0, 12'o0300,12'o0000);
    vecs[3] = mk("auto_wrap",0,   0,   1,   0,   12'o1410,12'o0000,12'o7777,0, 1, 12'o0000,3, 1, 1, 12'o0010,12'o0000);
    vecs[4] = mk("auto_w1",  0,   0,   1,   0,   12'o1415,12'o3000,12'o1234,1, 1, 12'o1235,5, 1, 1, 12'o0015,12'o1235);
    vecs[5] = mk("ind_w0",   0,   1,   0,   0,   12'o1477,12'o5000,12'o0042,0, 1, 12'o0042,2, 1, 0, 12'o0077,12'o0000);
    vecs[6] = mk("noflag",   0,   0,   0,   0,   12'o0055,12'o0000,12'o0000,0, 1, 12'o0055,1, 0, 0, 12'o0000,12'o0000);
    vecs[7] = mk("all_flags",1,   1,   1,   0,   12'o1417,12'o0000,12'o0100,0, 1, 12'o0101,3, 1, 1, 12'o0017,12'o0101);
    vecs[8] = mk("ind_dir",  1,   1,   0,   1,   12'o1520,12'o7600,12'o3333,0, 1, 12'o3333,2, 1, 0, 12'o7720,12'o0000);
    // START held through the busy cycles must not launch a second access.
    vecs[9] = mk("start_busy",0,  1,   0,   0,   12'o1460,12'o0000,12'o2222,3, 3, 12'o2222,5, 1, 0, 12'o0060,12'o0000);

    RESET = 1'b1; START = 1'b0; IR = '0; PCLATCHED = '0;
    DIR = 1'b0; IND = 1'b0; PPIND = 1'b0; MP = 1'b0;
    MEM_RDATA = '0; MEM_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst MEM_ADDR", MEM_ADDR, 0);
    chk("rst MEM_RD", MEM_RD, 0);
    chk("rst MEM_WR", MEM_WR, 0);
    chk("rst MEM_WDATA", MEM_WDATA, 0);
    chk("rst BUSY", BUSY, 0);
    chk("rst DONE", DONE, 0);
    chk("rst EA", EA, 0);
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Spurious MEM_ACK while idle: nothing may move.
    @(negedge CLK);
    MEM_ACK = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("spur_ack BUSY", BUSY, 0);
      chk("spur_ack DONE", DONE, 0);
      chk("spur_ack strobes", {MEM_RD, MEM_WR}, 0);
      chk("spur_ack EA", EA, 12'o2222);
    end
    MEM_ACK = 1'b0;

    // Reset while the write-back is pending.
    @(negedge CLK);
    IR = 12'o1410; PCLATCHED = '0; DIR = 1'b0; IND = 1'b0; PPIND = 1'b1; MP = 1'b0;
    START = 1'b1;
    found = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      START = 1'b0;
      MEM_ACK = 1'b0;
      if (MEM_WR) begin
        found = 1;
        break;
      end
      if (MEM_RD) begin
        MEM_ACK = 1'b1;
        MEM_RDATA = 12'o0005;
      end
    end
    MEM_ACK = 1'b0;
    chk("rstwr reached_WR", found, 1);
    chk("rstwr wdata_before", MEM_WDATA, 12'o0006);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("rstwr MEM_WR", MEM_WR, 0);
    chk("rstwr MEM_RD", MEM_RD, 0);
    chk("rstwr MEM_ADDR", MEM_ADDR, 0);
    chk("rstwr MEM_WDATA", MEM_WDATA, 0);
    chk("rstwr BUSY", BUSY, 0);
    chk("rstwr DONE", DONE, 0);
    chk("rstwr EA", EA, 0);
    // A late ack for the abandoned write must be ignored.
    MEM_ACK = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      MEM_ACK = 1'b0;
      chk("rstwr no_done", DONE, 0);
      chk("rstwr idle", BUSY, 0);
    end
    run_txn(mk("post_rst_dir", 1, 0, 0, 1, 12'o1377, 12'o2100, 12'o0000, 0, 1,
               12'o2177, 1, 0, 0, 12'o0000, 12'o0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
